csrhpmevent: RTL and testbench
==============================

# csrhpmevent

Event-selection and overflow controller for the hardware performance counters. It holds the `mhpmevent` CSRs for counters 3..COUNTERS-1 and routes one of 32 event sources to each counter. It produces per-counter increment enables, filtered by privilege mode and `mcountinhibit`. It records counter overflow in sticky OF bits and raises the local counter-overflow interrupt (LCOFI) for the trap logic. It sits beside the counter bank in the privileged unit: the counters consume `CounterIncM` and return their carry-out.

## Interface
- P, (none), cvw_t configuration; uses P.XLEN, P.COUNTERS (≤32), P.U_MODE, P.S_MODE.
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- CSRMWriteM  in  1  M-mode CSR write strobe.
- CSRAdrM  in  12  CSR address.
- CSRWriteValM  in  XLEN  CSR write data.
- PrivilegeModeW  in  2  current privilege mode.
- InstrValidNotFlushedM  in  1  instruction retires this cycle.
- EventM  in  32  raw event vector, indexed by event id; bit 0 is ignored.
- CounterOverflowM  in  COUNTERS  counter i is at all-ones and increments this cycle.
- MCOUNTINHIBIT_REGW, MCOUNTEREN_REGW  in  32 each  inhibit and enable CSRs.
- CounterIncM  out  COUNTERS  increment enable to each counter.
- HpmReadValM  out  XLEN  read data for decoded addresses.
- HpmAdrHitM  out  1  CSRAdrM decodes to a register owned by this block.
- OverflowVecM  out  32  OF bits, bit i = counter i; bits 0..2 are always 0.
- LCOFIPM  out  1  overflow interrupt pending.

## Operation
- Per counter i in 3..COUNTERS-1, registered state:
  - SEL[7:0], event select.
  - OF, sticky overflow bit.
  - MINH, SINH, UINH, mode inhibits.
- Register layout:
  - XLEN=64: `mhpmevent` at 0x320+i holds OF[63], MINH[62], SINH[61], UINH[60] and SEL[7:0]; all other bits read 0.
  - XLEN=32: 0x320+i holds SEL[7:0].
  - XLEN=32: `mhpmeventh` at 0x720+i holds OF[31], MINH[30], SINH[29], UINH[28].
- Writes: on CSRMWriteM with a matching address, fields load from CSRWriteValM on the next edge.
  - SEL stores the full 8 bits.
  - Any SEL value of 0 or ≥32 counts nothing.
- Increment enables:
  - CounterIncM[0] = ~MCOUNTINHIBIT[0].
  - CounterIncM[1] = 0.
  - CounterIncM[2] = InstrValidNotFlushedM & ~MCOUNTINHIBIT[2].
  - For i≥3: CounterIncM[i] = valid(SEL) & EventM[SEL] & ~MCOUNTINHIBIT[i] & ~modeinh.
  - modeinh is MINH in M mode, SINH in S mode, UINH in U mode.
- Overflow: CounterOverflowM[i] & CounterIncM[i] sets OF[i] on the next edge.
  - If a software write to the same field lands in the same cycle, the hardware set wins and OF ends at 1.
  - Software clears OF only by writing 0 when no overflow occurs in that cycle.
  - Counters 0..2 have no OF bit; their overflow input is ignored.
- `scountovf` (0xDA0):
  - Reads the OF vector masked by MCOUNTEREN_REGW when PrivilegeModeW = S.
  - Reads the unmasked OF vector in M mode.
  - Writes to it are ignored.
  - OverflowVecM is always the unmasked vector.
- LCOFIPM = OR of all OF bits; it comes from registered state only.
- Reads are combinational from CSRAdrM:
  - HpmAdrHitM=1 for 0x323..0x31F+COUNTERS, for 0xDA0, and, when XLEN=32, for 0x723..0x71F+COUNTERS.
  - Otherwise HpmReadValM=0 and HpmAdrHitM=0.
  - Addresses 0x320..0x322 (and 0x720..0x722) are not hit.

## Timing
- Reset, asynchronous: every SEL, OF and inhibit bit clears immediately.
  - Outputs after reset: LCOFIPM=0, OverflowVecM=0, HpmReadValM=0 for every event address.
  - CounterIncM[i≥3]=0.
  - CounterIncM[0..2] follow their inputs.
- CounterIncM has zero latency: combinational in the same cycle as EventM. The counter updates on that cycle's edge.
- Write to SEL or inhibit at edge N: takes effect for events in cycle N+1. Events in the write cycle use the old configuration.
- Overflow in cycle N: OF=1 and LCOFIPM=1 from cycle N+1, held until cleared.
- Clear by write at edge N: LCOFIPM drops in cycle N+1 if no other OF is set and no overflow occurs in cycle N.
- Reset asserted mid-operation: cancels any pending write or overflow set in that cycle.
- Multiple counters overflowing in the same cycle: each sets its own OF independently.

## Test plan
- Reset, then read 0x323 and `scountovf` -> both read 0. CounterIncM[3]=0 with EventM=32'hFFFF_FFFE.
- Write 0x323=8'h05. Pulse EventM[5] for 3 cycles, then EventM[4] -> CounterIncM[3]=1 for exactly those 3 cycles, then 0. Reads return 5.
- XLEN=64: program SEL=5 and UINH=1 (write 0x1000_0000_0000_0005) -> CounterIncM[3]=0 in U mode with EventM[5]=1, and 1 in M mode.
- CounterOverflowM[4]=1 with CounterIncM[4]=1 in cycle N -> OF[4]=1 and LCOFIPM=1 at N+1. `scountovf` reads 32'h10 in M mode; in S mode with MCOUNTEREN=0 it reads 0.
- Software writes OF=0 in the same cycle as a new overflow -> OF stays 1. The next write of 0 with no overflow -> LCOFIPM=0 one cycle later.
- Write SEL=8'h40 -> CounterIncM stays 0 for every EventM pattern. A read returns 8'h40.

Source files
------------

// File: rtl/csrhpmevent.sv
// Hardware performance monitor event selection, mode filtering and sticky overflow
// tracking for counters 3..COUNTERS-1, plus the scountovf view and LCOFI request.
module csrhpmevent #(
    parameter int XLEN     = 64,
    parameter int COUNTERS = 32,
    parameter bit U_MODE   = 1'b1,
    parameter bit S_MODE   = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                CSRMWriteM,
    input  logic [11:0]         CSRAdrM,
    input  logic [XLEN-1:0]     CSRWriteValM,
    input  logic [1:0]          PrivilegeModeW,
    input  logic                InstrValidNotFlushedM,
    input  logic [31:0]         EventM,
    input  logic [COUNTERS-1:0] CounterOverflowM,
    input  logic [31:0]         MCOUNTINHIBIT_REGW,
    input  logic [31:0]         MCOUNTEREN_REGW,
    output logic [COUNTERS-1:0] CounterIncM,
    output logic [XLEN-1:0]     HpmReadValM,
    output logic                HpmAdrHitM,
    output logic [31:0]         OverflowVecM,
    output logic                LCOFIPM
);

    localparam logic [1:0]  PRIV_U         = 2'd0;
    localparam logic [1:0]  PRIV_S         = 2'd1;
    localparam logic [1:0]  PRIV_M         = 2'd3;
    localparam logic [11:0] MHPMEVENT_BASE = 12'h320;
    localparam logic [11:0] MHPMEVENTH_BASE = 12'h720;
    localparam logic [11:0] SCOUNTOVF_ADR  = 12'hDA0;
    // On RV32 the OF/inhibit fields live in mhpmeventh; on RV64 they share mhpmevent.
    localparam logic [11:0] FLAGS_BASE     = (XLEN == 32) ? MHPMEVENTH_BASE : MHPMEVENT_BASE;

    logic [COUNTERS-1:0] ofBits, minhBits, sinhBits, uinhBits;
    logic [7:0]          selBits [COUNTERS];

    generate
        for (genvar gi = 0; gi < COUNTERS; gi++) begin : gCounter
            if (gi < 3) begin : gFixed
                assign ofBits[gi]   = 1'b0;
                assign minhBits[gi] = 1'b0;
                assign sinhBits[gi] = 1'b0;
                assign uinhBits[gi] = 1'b0;
                assign selBits[gi]  = '0;
                if (gi == 0) begin : gCycle
                    assign CounterIncM[gi] = ~MCOUNTINHIBIT_REGW[0];
                end else if (gi == 1) begin : gTime
                    assign CounterIncM[gi] = 1'b0;
                end else begin : gInstret
                    assign CounterIncM[gi] = InstrValidNotFlushedM & ~MCOUNTINHIBIT_REGW[2];
                end
            end else begin : gHpm
                logic [7:0] selReg;
                logic       ofReg, minhReg, sinhReg, uinhReg;
                logic       selWrite, flagWrite, modeInh, eventHit, overflowSet;

                assign selWrite  = CSRMWriteM & (CSRAdrM == MHPMEVENT_BASE + 12'(gi));
                assign flagWrite = CSRMWriteM & (CSRAdrM == FLAGS_BASE + 12'(gi));

                always_comb begin
                    case (PrivilegeModeW)
                        PRIV_M:  modeInh = minhReg;
                        PRIV_S:  modeInh = sinhReg;
                        PRIV_U:  modeInh = uinhReg;
                        default: modeInh = 1'b0;
                    endcase
                end

                // Select values 0 and 32..255 are legal to store but route no event.
                assign eventHit         = (selReg != 8'd0) && (selReg[7:5] == 3'd0) && EventM[selReg[4:0]];
                assign CounterIncM[gi]  = eventHit & ~MCOUNTINHIBIT_REGW[gi] & ~modeInh;
                assign overflowSet      = CounterOverflowM[gi] & CounterIncM[gi];

                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        selReg  <= '0;
                        ofReg   <= 1'b0;
                        minhReg <= 1'b0;
                        sinhReg <= 1'b0;
                        uinhReg <= 1'b0;
                    end else begin
                        if (selWrite) selReg <= CSRWriteValM[7:0];
                        if (flagWrite) begin
                            minhReg <= CSRWriteValM[XLEN-2];
                            sinhReg <= S_MODE & CSRWriteValM[XLEN-3];
                            uinhReg <= U_MODE & CSRWriteValM[XLEN-4];
                        end
                        // A hardware overflow beats a same-cycle software clear.
                        ofReg <= overflowSet | (flagWrite ? CSRWriteValM[XLEN-1] : ofReg);
                    end
                end

                assign ofBits[gi]   = ofReg;
                assign minhBits[gi] = minhReg;
                assign sinhBits[gi] = sinhReg;
                assign uinhBits[gi] = uinhReg;
                assign selBits[gi]  = selReg;
            end
        end
    endgenerate

    always_comb begin
        OverflowVecM               = '0;
        OverflowVecM[COUNTERS-1:0] = ofBits;
    end

    assign LCOFIPM = |ofBits;

    always_comb begin
        logic [63:0] rd64;
        rd64       = '0;
        HpmAdrHitM = 1'b0;
        for (int i = 3; i < COUNTERS; i++) begin
            if (CSRAdrM == MHPMEVENT_BASE + 12'(i)) begin
                HpmAdrHitM = 1'b1;
                rd64[7:0]  = selBits[i];
                if (XLEN == 64) rd64[63:60] = {ofBits[i], minhBits[i], sinhBits[i], uinhBits[i]};
            end
            if ((XLEN == 32) && (CSRAdrM == MHPMEVENTH_BASE + 12'(i))) begin
                HpmAdrHitM  = 1'b1;
                rd64[31:28] = {ofBits[i], minhBits[i], sinhBits[i], uinhBits[i]};
            end
        end
        if (CSRAdrM == SCOUNTOVF_ADR) begin
            HpmAdrHitM = 1'b1;
            rd64[31:0] = (PrivilegeModeW == PRIV_M) ? OverflowVecM : (OverflowVecM & MCOUNTEREN_REGW);
        end
        HpmReadValM = rd64[XLEN-1:0];
    end

    // Middle write-data bits, the time-counter inhibit and low-counter overflows are architecturally don't-care.
    logic unusedInputs;
    assign unusedInputs = &{1'b0, CSRWriteValM, MCOUNTINHIBIT_REGW, CounterOverflowM};

endmodule

// File: tb/tb_csrhpmevent.sv
// Bench for csrhpmevent (RV64, 32 counters): constant vector table, hand-written
// corner sequences, then random traffic against a field-level reference model.
module tb_csrhpmevent;

    localparam int XLEN     = 64;
    localparam int COUNTERS = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              CSRMWriteM;
    logic [11:0]       CSRAdrM;
    logic [XLEN-1:0]   CSRWriteValM;
    logic [1:0]        PrivilegeModeW;
    logic              InstrValidNotFlushedM;
    logic [31:0]       EventM;
    logic [COUNTERS-1:0] CounterOverflowM;
    logic [31:0]       MCOUNTINHIBIT_REGW, MCOUNTEREN_REGW;
    logic [COUNTERS-1:0] CounterIncM;
    logic [XLEN-1:0]   HpmReadValM;
    logic              HpmAdrHitM;
    logic [31:0]       OverflowVecM;
    logic              LCOFIPM;

    always #5 clk = ~clk;

    csrhpmevent #(.XLEN(XLEN), .COUNTERS(COUNTERS), .U_MODE(1'b1), .S_MODE(1'b1)) dut (
        .clk(clk), .reset(reset), .CSRMWriteM(CSRMWriteM), .CSRAdrM(CSRAdrM),
        .CSRWriteValM(CSRWriteValM), .PrivilegeModeW(PrivilegeModeW),
        .InstrValidNotFlushedM(InstrValidNotFlushedM), .EventM(EventM),
        .CounterOverflowM(CounterOverflowM), .MCOUNTINHIBIT_REGW(MCOUNTINHIBIT_REGW),
        .MCOUNTEREN_REGW(MCOUNTEREN_REGW), .CounterIncM(CounterIncM),
        .HpmReadValM(HpmReadValM), .HpmAdrHitM(HpmAdrHitM),
        .OverflowVecM(OverflowVecM), .LCOFIPM(LCOFIPM)
    );

    int nVec = 0;
    int nMis = 0;

    // Reference model: per-counter fields; inhibit looked up by privilege number (3=M,1=S,0=U).
    int mSel [32];
    bit mOf  [32];
    bit mInh [32][4];

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] ev;
        logic [31:0] inh;
        logic        valid;
        logic [31:0] expInc;
    } vec_t;
    vec_t tbl [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic void modelReset();
        for (int i = 0; i < 32; i++) begin
            mSel[i] = 0;
            mOf[i]  = 1'b0;
            for (int m = 0; m < 4; m++) mInh[i][m] = 1'b0;
        end
    endfunction

    function automatic bit [31:0] modelInc();
        bit [31:0] r;
        r    = '0;
        r[0] = !MCOUNTINHIBIT_REGW[0];
        r[2] = InstrValidNotFlushedM && !MCOUNTINHIBIT_REGW[2];
        for (int i = 3; i < 32; i++)
            r[i] = (mSel[i] >= 1) && (mSel[i] <= 31) && EventM[mSel[i]] &&
                   !MCOUNTINHIBIT_REGW[i] && !mInh[i][PrivilegeModeW];
        return r;
    endfunction

    function automatic bit [31:0] modelOfVec();
        bit [31:0] r;
        r = '0;
        for (int i = 3; i < 32; i++) r[i] = mOf[i];
        return r;
    endfunction

    function automatic logic [63:0] modelRead(input logic [11:0] a);
        logic [63:0] r;
        r = '0;
        if (a >= 12'h323 && a <= 12'h33F) begin
            int i;
            i = int'(a) - 'h320;
            r[7:0] = 8'(mSel[i]);
            r[63]  = mOf[i];
            r[62]  = mInh[i][3];
            r[61]  = mInh[i][1];
            r[60]  = mInh[i][0];
        end else if (a == 12'hDA0) begin
            r[31:0] = (PrivilegeModeW == 2'd3) ? modelOfVec() : (modelOfVec() & MCOUNTEREN_REGW);
        end
        return r;
    endfunction

    function automatic logic modelHit(input logic [11:0] a);
        return (a >= 12'h323 && a <= 12'h33F) || (a == 12'hDA0);
    endfunction

    function automatic void modelStep();
        bit [31:0] inc;
        int w;
        inc = modelInc();
        w   = -1;
        if (CSRMWriteM && CSRAdrM >= 12'h323 && CSRAdrM <= 12'h33F) w = int'(CSRAdrM) - 'h320;
        for (int i = 3; i < 32; i++) begin
            bit set;
            set = CounterOverflowM[i] && inc[i];
            if (i == w) begin
                mSel[i]    = int'(CSRWriteValM[7:0]);
                mInh[i][3] = CSRWriteValM[62];
                mInh[i][1] = CSRWriteValM[61];
                mInh[i][0] = CSRWriteValM[60];
                mOf[i]     = set || CSRWriteValM[63];
            end else begin
                mOf[i] = mOf[i] || set;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        if (reset) modelReset();
        else modelStep();
        @(negedge clk);
    endtask

    task automatic setIdle();
        CSRMWriteM            = 1'b0;
        CSRAdrM               = 12'h000;
        CSRWriteValM          = '0;
        PrivilegeModeW        = 2'd3;
        InstrValidNotFlushedM = 1'b0;
        EventM                = '0;
        CounterOverflowM      = '0;
        MCOUNTINHIBIT_REGW    = '0;
        MCOUNTEREN_REGW       = '0;
    endtask

    task automatic csrWrite(input logic [11:0] a, input logic [63:0] v);
        CSRMWriteM   = 1'b1;
        CSRAdrM      = a;
        CSRWriteValM = v;
        tick();
        CSRMWriteM   = 1'b0;
    endtask

    task automatic checkAll(input int cyc);
        check("inc",   64'(CounterIncM),  64'(modelInc()));
        check("ofvec", 64'(OverflowVecM), 64'(modelOfVec()));
        check("lcofi", 64'(LCOFIPM),      64'(|modelOfVec()));
        check("rdval", HpmReadValM,       modelRead(CSRAdrM));
        check("hit",   64'(HpmAdrHitM),   64'(modelHit(CSRAdrM)));
        $display("rnd %0d mode=%0d wr=%0b adr=%h inc=%h of=%h rd=%h", cyc, PrivilegeModeW,
                 CSRMWriteM, CSRAdrM, CounterIncM, OverflowVecM, HpmReadValM);
    endtask

    initial begin
        tbl[0] = '{2'd3, 32'h0000_0020, 32'h0, 1'b0, 32'h0000_0009};
        tbl[1] = '{2'd3, 32'h8000_0080, 32'h0, 1'b1, 32'h0000_0055};
        tbl[2] = '{2'd0, 32'h8000_0080, 32'h0, 1'b1, 32'h0000_0045};
        tbl[3] = '{2'd1, 32'h8000_0080, 32'h0, 1'b1, 32'h0000_0015};
        tbl[4] = '{2'd3, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000};
        tbl[5] = '{2'd3, 32'hFFFF_FFFE, 32'h0000_0009, 1'b1, 32'h0000_0054};
        tbl[6] = '{2'd0, 32'hFFFF_FFFF, 32'h0, 1'b0, 32'h0000_0049};
        tbl[7] = '{2'd1, 32'h8000_0020, 32'h0, 1'b0, 32'h0000_0009};

        setIdle();
        modelReset();
        @(negedge clk);
        tick();

        // Reset state
        CSRAdrM = 12'h323; #1;
        check("rst_rd323", HpmReadValM, 64'h0);
        check("rst_hit323", 64'(HpmAdrHitM), 64'h1);
        CSRAdrM = 12'hDA0; #1;
        check("rst_scountovf", HpmReadValM, 64'h0);
        EventM = 32'hFFFF_FFFE; InstrValidNotFlushedM = 1'b1; #1;
        check("rst_inc", 64'(CounterIncM), 64'h5);
        check("rst_lcofi", 64'(LCOFIPM), 64'h0);
        check("rst_ofvec", 64'(OverflowVecM), 64'h0);
        CSRAdrM = 12'h322; #1;
        check("nohit322", 64'(HpmAdrHitM), 64'h0);
        check("rd322", HpmReadValM, 64'h0);
        $display("reset checks done");
        setIdle();
        reset = 1'b0;
        tick();

        // SEL=5, three event-5 cycles then event 4
        csrWrite(12'h323, 64'h5);
        for (int k = 0; k < 4; k++) begin
            EventM  = (k < 3) ? 32'h20 : 32'h10;
            CSRAdrM = 12'h323; #1;
            check($sformatf("pulse_inc3_%0d", k), 64'(CounterIncM[3]), (k < 3) ? 64'h1 : 64'h0);
            check($sformatf("pulse_rd_%0d", k), HpmReadValM, 64'h5);
            $display("pulse %0d ev=%h inc=%h", k, EventM, CounterIncM);
            tick();
        end
        EventM = '0;

        // Table: c4 SEL7+UINH, c5 SEL 0x40, c6 SEL31+SINH, c7 SEL0+MINH
        csrWrite(12'h324, 64'h1000_0000_0000_0007);
        csrWrite(12'h325, 64'h40);
        csrWrite(12'h326, 64'h2000_0000_0000_001F);
        csrWrite(12'h327, 64'h4000_0000_0000_0000);
        CSRAdrM = 12'h325; #1;
        check("rd_sel40", HpmReadValM, 64'h40);
        CSRAdrM = 12'h324; #1;
        check("rd_uinh", HpmReadValM, 64'h1000_0000_0000_0007);
        for (int k = 0; k < 8; k++) begin
            PrivilegeModeW        = tbl[k].mode;
            EventM                = tbl[k].ev;
            MCOUNTINHIBIT_REGW    = tbl[k].inh;
            InstrValidNotFlushedM = tbl[k].valid; #1;
            check($sformatf("tbl%0d", k), 64'(CounterIncM), 64'(tbl[k].expInc));
            $display("tbl %0d mode=%0d ev=%h inh=%h inc=%h", k, PrivilegeModeW, EventM,
                     MCOUNTINHIBIT_REGW, CounterIncM);
            tick();
        end
        setIdle();

        // A write's own cycle still uses the old select
        CSRMWriteM = 1'b1; CSRAdrM = 12'h323; CSRWriteValM = 64'h7; EventM = 32'h20; #1;
        check("wr_oldcfg", 64'(CounterIncM[3]), 64'h1);
        tick();
        CSRMWriteM = 1'b0; #1;
        check("wr_newcfg_ev5", 64'(CounterIncM[3]), 64'h0);
        EventM = 32'h80; #1;
        check("wr_newcfg_ev7", 64'(CounterIncM[3]), 64'h1);

        // Overflow of counter 4
        CounterOverflowM = 32'h10; #1;
        check("ovf_inc4", 64'(CounterIncM[4]), 64'h1);
        check("ovf_lcofi_before", 64'(LCOFIPM), 64'h0);
        tick();
        EventM = '0; CounterOverflowM = '0; CSRAdrM = 12'hDA0; #1;
        check("ovf_vec", 64'(OverflowVecM), 64'h10);
        check("ovf_lcofi", 64'(LCOFIPM), 64'h1);
        check("scountovf_m", HpmReadValM, 64'h10);
        PrivilegeModeW = 2'd1; #1;
        check("scountovf_s_masked", HpmReadValM, 64'h0);
        MCOUNTEREN_REGW = 32'h10; #1;
        check("scountovf_s_en", HpmReadValM, 64'h10);
        PrivilegeModeW = 2'd3; MCOUNTEREN_REGW = '0;

        // Writes to scountovf are ignored
        csrWrite(12'hDA0, 64'h0); #1;
        check("scountovf_wr_ignored", HpmReadValM, 64'h10);

        // Software clear collides with a fresh overflow: hardware set wins
        EventM = 32'h80; CounterOverflowM = 32'h10;
        csrWrite(12'h324, 64'h1000_0000_0000_0007);
        EventM = '0; CounterOverflowM = '0; CSRAdrM = 12'h324; #1;
        check("clr_collide_rd", HpmReadValM, 64'h9000_0000_0000_0007);
        check("clr_collide_lcofi", 64'(LCOFIPM), 64'h1);
        csrWrite(12'h324, 64'h1000_0000_0000_0007); #1;
        check("clr_lcofi", 64'(LCOFIPM), 64'h0);
        check("clr_vec", 64'(OverflowVecM), 64'h0);

        // Overflow without increment, and on counters 0..2, is ignored
        CounterOverflowM = '1; InstrValidNotFlushedM = 1'b1; #1;
        check("noinc_inc", 64'(CounterIncM), 64'h5);
        tick();
        CounterOverflowM = '0; #1;
        check("noinc_vec", 64'(OverflowVecM), 64'h0);

        // Two counters overflow in one cycle
        EventM = 32'h8000_0080; CounterOverflowM = 32'h48;
        tick();
        EventM = '0; CounterOverflowM = '0; #1;
        check("multi_vec", 64'(OverflowVecM), 64'h48);
        check("multi_lcofi", 64'(LCOFIPM), 64'h1);

        // Reset lands during a pending write and overflow set
        CSRMWriteM = 1'b1; CSRAdrM = 12'h323; CSRWriteValM = 64'h8000_0000_0000_0009;
        EventM = 32'h80; CounterOverflowM = 32'h10;
        #2 reset = 1'b1;
        modelReset(); #1;
        check("arst_vec", 64'(OverflowVecM), 64'h0);
        check("arst_lcofi", 64'(LCOFIPM), 64'h0);
        check("arst_rd323", HpmReadValM, 64'h0);
        check("arst_inc3", 64'(CounterIncM[3]), 64'h0);
        tick();
        setIdle();
        reset = 1'b0;
        CSRAdrM = 12'h323; #1;
        check("arst_wr_cancel", HpmReadValM, 64'h0);
        check("arst_vec_after", 64'(OverflowVecM), 64'h0);

        // Random traffic against the model
        for (int c = 0; c < 400; c++) begin
            int r;
            logic [63:0] d;
            logic [11:0] a;
            r = $urandom_range(0, 9);
            if (r < 8)      a = 12'h320 + 12'($urandom_range(0, 32));
            else if (r == 8) a = 12'hDA0;
            else            a = 12'h720 + 12'($urandom_range(0, 31));
            d = {$urandom, $urandom};
            d[7:0] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 31));
            case ($urandom_range(0, 2))
                0:       PrivilegeModeW = 2'd0;
                1:       PrivilegeModeW = 2'd1;
                default: PrivilegeModeW = 2'd3;
            endcase
            EventM                = $urandom;
            MCOUNTINHIBIT_REGW    = $urandom & $urandom & $urandom;
            MCOUNTEREN_REGW       = $urandom;
            InstrValidNotFlushedM = 1'($urandom_range(0, 1));
            CounterOverflowM      = $urandom & $urandom & $urandom;
            CSRMWriteM            = ($urandom_range(0, 2) == 0);
            CSRAdrM               = a;
            CSRWriteValM          = d;
            #1;
            checkAll(c);
            tick();
        end
        setIdle();

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
